hm_exp_loader: RTL and testbench
================================

Name: hm_exp_loader

Overview:
- Fills the two 32-bit expansion-ROM banks (low/high dword interleave) that the PCIe memory-read completer serves to the host.
- Accepts a ROM image as a 32-bit valid/ready word stream, writes each word into the correct bank, and validates the image:
  - 0x55AA signature;
  - size byte;
  - 8-bit byte checksum.
- Raises `rom_ready` only for a valid image, and counts the completer's `read_exp` pulses for status.

Parameters:
- `MAX_DW`, 2048, maximum image length in dwords. Equals bank depth × 2; each bank is 1024 × 32.

Ports:
- `trn_clk` in 1: single clock for all logic.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load. Ignored unless the state is IDLE or READY.
- `len_dw` in 12: image length in dwords, sampled on `start`.
- `s_data` in 32: stream word. Raw little-endian ROM bytes; byte 0 is in `s_data[7:0]`.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word this cycle.
- `mem_l_we` out 1: low-bank write enable.
- `mem_l_addr` out 10: low-bank write address.
- `mem_l_data` out 32: low-bank write data.
- `mem_h_we` out 1: high-bank write enable.
- `mem_h_addr` out 10: high-bank write address.
- `mem_h_data` out 32: high-bank write data.
- `read_exp` in 1: pulse from the completer when the host has read the last ROM byte.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse at the end of a load, whether it passed or failed.
- `rom_ready` out 1: a valid image is resident.
- `err_len` out 1: the length is illegal or does not match the header.
- `err_sig` out 1: the signature is bad.
- `err_sum` out 1: the checksum is non-zero.
- `exp_read_cnt` out 16: number of `read_exp` pulses while `rom_ready` is high.

Behaviour:
- Reset (`sys_rst` high at a `trn_clk` edge): every output is 0, the state is IDLE, and the word counter `wc` and checksum `sum` are 0. Reset wins over every other event, including mid-load; a partially written bank is left as is, with `rom_ready` = 0.
- States: IDLE, LOAD, CHECK, READY.
- IDLE/READY with `start` = 1:
  - Clear `rom_ready`, all `err_*`, `wc`, `sum` and `exp_read_cnt`.
  - Latch `len_dw`.
  - If `len_dw` = 0 or `len_dw` > `MAX_DW`: set `err_len`, pulse `done` in the next cycle, and go to IDLE without accepting any word.
  - Otherwise go to LOAD.
- LOAD:
  - `s_ready` = 1 combinationally while in LOAD and `wc` < `len_dw`.
  - Each handshake (`s_valid` & `s_ready`) increments `wc`, adds the four bytes of `s_data` to the 8-bit `sum` (mod 256), and issues a registered write in the next cycle.
  - Bank select is `wc[0]`:
    - even `wc` → `mem_l_we` = 1, `mem_l_addr` = `wc[10:1]`, `mem_l_data` = `s_data`;
    - odd `wc` → same on the high bank.
  - The two `we` signals are never high together and each is high for exactly one cycle per word. Data is stored unswapped; the completer performs the byte swap.
  - Word 0 checks:
    - `err_sig` is set if `s_data[15:0]` ≠ 16'hAA55.
    - `err_len` is set if `s_data[23:16]` × 128 ≠ `len_dw`. A size byte of 0 always mismatches.
  - When the handshake with `wc` = `len_dw`−1 occurs, the state becomes CHECK on the next edge.
  - `start` is ignored in LOAD and CHECK. `s_valid` gaps simply stall the load; there is no timeout.
- CHECK: lasts one cycle.
  - `err_sum` = (`sum` ≠ 0).
  - `done` pulses.
  - If there are no errors: `rom_ready` = 1 and the state becomes READY; otherwise the state becomes IDLE.
  - Error flags hold until the next `start` or reset.
- READY:
  - Each `read_exp` pulse increments `exp_read_cnt`, saturating at 16'hFFFF.
  - `read_exp` is ignored in other states.
  - If `read_exp` and `start` occur in the same cycle, `start` wins and the counter clears.
- `busy` = 1 in LOAD and CHECK.
- Latency: the last word's handshake occurs at cycle t. Its bank write and CHECK are at t+1; `done` and `rom_ready` are visible at t+2.
- Arithmetic: `wc` is 12-bit and cannot wrap because `len_dw` ≤ 2048. Bank addresses use `wc[10:1]`.

Test Plan:
- Valid 512-byte image, `len_dw` = 128, word0 = 32'h0001AA55, last word adjusted for sum = 0, continuous `s_valid` → 64 low and 64 high writes at addresses 0..63. `done` arrives two cycles after the last handshake, with `rom_ready` = 1 and all `err_*` = 0.
- Same image with the last byte incremented by 1 → `err_sum` = 1, `rom_ready` = 0, final state IDLE.
- Word0 = 32'h0001AA56 → `err_sig` = 1. Word0 = 32'h0002AA55 with `len_dw` = 128 → `err_len` = 1. In both cases all 128 words are still accepted.
- `len_dw` = 0, then `len_dw` = 2049 → `s_ready` never asserts, `err_len` = 1, one `done` pulse each.
- 8 KB image (`len_dw` = 2048, size byte 16) with random `s_valid` gaps → final writes go to `mem_l_addr` = 1023 and `mem_h_addr` = 1023, and `rom_ready` = 1.
- In READY, 3 `read_exp` pulses → `exp_read_cnt` = 3. Assert `sys_rst` mid-load at `wc` = 50 → all outputs are 0 next cycle and a new `start` reloads cleanly.

Source files
------------

// File: rtl/hm_exp_loader_if.sv
// Valid/ready word stream carrying the expansion-ROM image into the loader.
interface hm_exp_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/hm_exp_loader.sv
// Writes a streamed expansion-ROM image into the low/high dword banks and validates
// its signature, size byte and byte checksum before declaring the ROM ready.
module hm_exp_loader #(
   parameter int unsigned MAX_DW = 2048
) (
   input  logic                 trn_clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [11:0]          len_dw,
   hm_exp_loader_if.slave       s,
   output logic                 mem_l_we,
   output logic [9:0]           mem_l_addr,
   output logic [31:0]          mem_l_data,
   output logic                 mem_h_we,
   output logic [9:0]           mem_h_addr,
   output logic [31:0]          mem_h_data,
   input  logic                 read_exp,
   output logic                 busy,
   output logic                 done,
   output logic                 rom_ready,
   output logic                 err_len,
   output logic                 err_sig,
   output logic                 err_sum,
   output logic [15:0]          exp_read_cnt
);

   typedef enum logic [1:0] {StIdle, StLoad, StCheck, StReady} state_e;

   localparam logic [12:0] MaxDw = 13'(MAX_DW);

   state_e      state;
   logic [11:0] wc;
   logic [11:0] len_q;
   logic [7:0]  sum;

   logic        hs;
   logic [7:0]  word_sum;
   logic        len_bad;
   logic        size_bad;

   assign s.s_ready = (state == StLoad) && (wc < len_q);
   assign hs        = s.s_valid && s.s_ready;
   assign word_sum  = s.s_data[7:0] + s.s_data[15:8] + s.s_data[23:16] + s.s_data[31:24];
   assign len_bad   = (len_dw == 12'd0) || ({1'b0, len_dw} > MaxDw);
   // Size byte counts 512-byte blocks, i.e. 128 dwords each.
   assign size_bad  = {s.s_data[23:16], 7'd0} != {3'd0, len_q};
   assign busy      = (state == StLoad) || (state == StCheck);

   always_ff @(posedge trn_clk) begin
      if (sys_rst) begin
         state        <= StIdle;
         wc           <= '0;
         len_q        <= '0;
         sum          <= '0;
         mem_l_we     <= 1'b0;
         mem_l_addr   <= '0;
         mem_l_data   <= '0;
         mem_h_we     <= 1'b0;
         mem_h_addr   <= '0;
         mem_h_data   <= '0;
         done         <= 1'b0;
         rom_ready    <= 1'b0;
         err_len      <= 1'b0;
         err_sig      <= 1'b0;
         err_sum      <= 1'b0;
         exp_read_cnt <= '0;
      end else begin
         done     <= 1'b0;
         mem_l_we <= 1'b0;
         mem_h_we <= 1'b0;
         case (state)
            StIdle, StReady: begin
               if (start) begin
                  rom_ready    <= 1'b0;
                  err_len      <= 1'b0;
                  err_sig      <= 1'b0;
                  err_sum      <= 1'b0;
                  wc           <= '0;
                  sum          <= '0;
                  exp_read_cnt <= '0;
                  len_q        <= len_dw;
                  if (len_bad) begin
                     err_len <= 1'b1;
                     done    <= 1'b1;
                     state   <= StIdle;
                  end else begin
                     state   <= StLoad;
                  end
               end else if (state == StReady && read_exp && exp_read_cnt != 16'hFFFF) begin
                  exp_read_cnt <= exp_read_cnt + 16'd1;
               end
            end
            StLoad: begin
               if (hs) begin
                  wc  <= wc + 12'd1;
                  sum <= sum + word_sum;
                  if (wc[0]) begin
                     mem_h_we   <= 1'b1;
                     mem_h_addr <= wc[10:1];
                     mem_h_data <= s.s_data;
                  end else begin
                     mem_l_we   <= 1'b1;
                     mem_l_addr <= wc[10:1];
                     mem_l_data <= s.s_data;
                  end
                  if (wc == 12'd0) begin
                     if (s.s_data[15:0] != 16'hAA55) err_sig <= 1'b1;
                     if (size_bad)                   err_len <= 1'b1;
                  end
                  if (wc == len_q - 12'd1) state <= StCheck;
               end
            end
            StCheck: begin
               err_sum <= (sum != 8'd0);
               done    <= 1'b1;
               if (!err_len && !err_sig && sum == 8'd0) begin
                  rom_ready <= 1'b1;
                  state     <= StReady;
               end else begin
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hm_exp_loader.sv
// Directed and randomized checks of the expansion-ROM loader against an image-level model.
module tb_hm_exp_loader;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        start;
   logic [11:0] len_dw;
   logic        mem_l_we, mem_h_we;
   logic [9:0]  mem_l_addr, mem_h_addr;
   logic [31:0] mem_l_data, mem_h_data;
   logic        read_exp;
   logic        busy, done, rom_ready, err_len, err_sig, err_sum;
   logic [15:0] exp_read_cnt;

   hm_exp_loader_if s_if ();

   hm_exp_loader #(.MAX_DW(2048)) dut (
      .trn_clk      (clk),
      .sys_rst      (sys_rst),
      .start        (start),
      .len_dw       (len_dw),
      .s            (s_if),
      .mem_l_we     (mem_l_we),
      .mem_l_addr   (mem_l_addr),
      .mem_l_data   (mem_l_data),
      .mem_h_we     (mem_h_we),
      .mem_h_addr   (mem_h_addr),
      .mem_h_data   (mem_h_data),
      .read_exp     (read_exp),
      .busy         (busy),
      .done         (done),
      .rom_ready    (rom_ready),
      .err_len      (err_len),
      .err_sig      (err_sig),
      .err_sum      (err_sum),
      .exp_read_cnt (exp_read_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] img [0:2047];

   // Bank scoreboard fed from the write ports.
   logic [31:0] sb_l [0:1023];
   logic [31:0] sb_h [0:1023];
   int          wr_l = 0, wr_h = 0, both_we = 0;
   logic [9:0]  last_l = '0, last_h = '0;

   always @(negedge clk) begin
      if (mem_l_we && mem_h_we) both_we <= both_we + 1;
      if (mem_l_we) begin
         sb_l[mem_l_addr] <= mem_l_data;
         wr_l             <= wr_l + 1;
         last_l           <= mem_l_addr;
      end
      if (mem_h_we) begin
         sb_h[mem_h_addr] <= mem_h_data;
         wr_h             <= wr_h + 1;
         last_h           <= mem_h_addr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] img_sum(input int len);
      logic [7:0] acc = 8'd0;
      for (int i = 0; i < len; i++)
         acc = acc + img[i][7:0] + img[i][15:8] + img[i][23:16] + img[i][31:24];
      return acc;
   endfunction

   task automatic build_img(input int len, input logic [7:0] size, input logic [15:0] sig,
                            input bit fix);
      logic [7:0] s;
      img[0] = {8'h00, size, sig};
      for (int i = 1; i < len; i++) img[i] = $urandom;
      if (fix) begin
         img[len-1][31:24] = 8'h00;
         s = img_sum(len);
         img[len-1][31:24] = 8'h00 - s;
      end
   endtask

   task automatic do_load(input string tag, input int len, input int gap, input bit rd_start);
      int   i = 0, cyc = 0, wl0, wh0, bad = 0;
      bit   hs;
      logic e_sig, e_len, e_sum, e_rdy;
      logic [31:0] d;
      e_sig = (img[0][15:0] != 16'hAA55);
      e_len = ((int'(img[0][23:16]) * 128) != len);
      e_sum = (img_sum(len) != 8'd0);
      e_rdy = !(e_sig || e_len || e_sum);
      wl0 = wr_l;
      wh0 = wr_h;
      start    = 1'b1;
      len_dw   = 12'(len);
      read_exp = rd_start;
      tick();
      start    = 1'b0;
      read_exp = 1'b0;
      chk({tag, "_busy_load"}, 32'(busy), 32'd1);
      chk({tag, "_cnt_clear"}, 32'(exp_read_cnt), 32'd0);
      while (i < len && cyc < len * 20 + 50) begin
         s_if.s_valid = ($urandom_range(99) >= gap);
         s_if.s_data  = s_if.s_valid ? img[i] : $urandom;
         hs = s_if.s_valid && s_if.s_ready;
         tick();
         if (hs) i++;
         cyc++;
      end
      s_if.s_valid = 1'b0;
      chk({tag, "_words_accepted"}, 32'(i), 32'(len));
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      tick();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_rom_ready"}, 32'(rom_ready), 32'(e_rdy));
      chk({tag, "_err_flags"}, 32'({err_len, err_sig, err_sum}), 32'({e_len, e_sig, e_sum}));
      chk({tag, "_wr_l_cnt"}, 32'(wr_l - wl0), 32'((len + 1) / 2));
      chk({tag, "_wr_h_cnt"}, 32'(wr_h - wh0), 32'(len / 2));
      chk({tag, "_last_l"}, 32'(last_l), 32'((len - 1) / 2));
      if (len >= 2) chk({tag, "_last_h"}, 32'(last_h), 32'((len - 2) / 2));
      for (int k = 0; k < len; k++) begin
         d = (k % 2 == 1) ? sb_h[k/2] : sb_l[k/2];
         if (d !== img[k]) bad++;
      end
      chk({tag, "_bank_words_bad"}, 32'(bad), 32'd0);
      chk({tag, "_both_we"}, 32'(both_we), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
   endtask

   task automatic bad_len(input string tag, input int len);
      int dn = 0, sr = 0;
      start  = 1'b1;
      len_dw = 12'(len);
      tick();
      start  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (done) dn++;
         if (s_if.s_ready) sr++;
         tick();
      end
      chk({tag, "_done_pulses"}, 32'(dn), 32'd1);
      chk({tag, "_s_ready"}, 32'(sr), 32'd0);
      chk({tag, "_err_len"}, 32'({err_len, err_sig, err_sum, rom_ready, busy}), 32'h10);
   endtask

   initial begin
      logic [108:0] outs;
      int           rl;
      sys_rst = 1'b1;
      start = 1'b0;
      len_dw = '0;
      read_exp = 1'b0;
      s_if.s_valid = 1'b0;
      s_if.s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      outs = {s_if.s_ready, mem_l_we, mem_l_addr, mem_l_data, mem_h_we, mem_h_addr, mem_h_data,
              busy, done, rom_ready, err_len, err_sig, err_sum, exp_read_cnt};
      chk("reset_outputs", 32'(outs != '0), 32'd0);
      sys_rst = 1'b0;
      tick();

      // Valid 128-dword image, continuous valid.
      build_img(128, 8'h01, 16'hAA55, 1'b1);
      chk("img_word0", img[0], 32'h0001AA55);
      do_load("valid128", 128, 0, 1'b0);

      for (int p = 0; p < 3; p++) begin
         read_exp = 1'b1;
         tick();
         read_exp = 1'b0;
         tick();
      end
      chk("read_exp_cnt3", 32'(exp_read_cnt), 32'd3);

      // Bad checksum; start coincides with read_exp and must win.
      img[127][31:24] = img[127][31:24] + 8'd1;
      do_load("badsum", 128, 0, 1'b1);
      read_exp = 1'b1;
      tick();
      read_exp = 1'b0;
      tick();
      chk("read_exp_ignored_idle", 32'(exp_read_cnt), 32'd0);

      build_img(128, 8'h01, 16'hAA56, 1'b1);
      do_load("badsig", 128, 0, 1'b0);
      build_img(128, 8'h02, 16'hAA55, 1'b1);
      do_load("badsize", 128, 0, 1'b0);

      bad_len("len0", 0);
      bad_len("len2049", 2049);

      build_img(2048, 8'h10, 16'hAA55, 1'b1);
      do_load("full8k", 2048, 30, 1'b0);

      // Randomized images, some corrupted.
      for (int r = 0; r < 4; r++) begin
         rl = ($urandom_range(1) == 1) ? 128 * int'($urandom_range(1, 3)) : int'($urandom_range(1, 300));
         build_img(rl, ($urandom_range(1) == 1) ? 8'(rl / 128) : 8'($urandom_range(255)),
                   ($urandom_range(3) != 0) ? 16'hAA55 : 16'($urandom), $urandom_range(1) == 1);
         do_load($sformatf("rand%0d", r), rl, 40, 1'b0);
      end

      // Reset in the middle of a load at wc = 50, then reload.
      build_img(128, 8'h01, 16'hAA55, 1'b1);
      start  = 1'b1;
      len_dw = 12'd128;
      tick();
      start = 1'b0;
      begin
         int i = 0, cyc = 0;
         while (i < 50 && cyc < 200) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = img[i];
            if (s_if.s_ready) i++;
            tick();
            cyc++;
         end
         chk("midrst_words", 32'(i), 32'd50);
      end
      chk("midrst_busy", 32'(busy), 32'd1);
      s_if.s_data = img[50];
      sys_rst = 1'b1;
      tick();
      outs = {s_if.s_ready, mem_l_we, mem_l_addr, mem_l_data, mem_h_we, mem_h_addr, mem_h_data,
              busy, done, rom_ready, err_len, err_sig, err_sum, exp_read_cnt};
      chk("midrst_outputs", 32'(outs != '0), 32'd0);
      sys_rst = 1'b0;
      s_if.s_valid = 1'b0;
      tick();
      do_load("reload", 128, 10, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
